// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic unit (multiplier and divider).
// Holds the common FSM state encoding and the default operand width.
package arith_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } arith_state_e;

   localparam int ARITH_WIDTH = 4;

endpackage

// File: rtl/seq_mul_if.sv
// Start/done handshake bundle for the iterative multiplier.
// The requester uses the master modport and the multiplier uses the slave modport.
interface seq_mul_if
   import arith_pkg::*;
#(
   parameter int WIDTH = ARITH_WIDTH
);

   logic                 start;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 is_signed;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;

   modport master (
      output start,
      output a,
      output b,
      output is_signed,
      input  busy,
      input  done,
      input  product
   );

   modport slave (
      input  start,
      input  a,
      input  b,
      input  is_signed,
      output busy,
      output done,
      output product
   );

endinterface

// File: rtl/seq_mul.sv
// Iterative shift-and-add multiplier producing one partial product per clock.
// Signed operands are handled as sign plus magnitude, and the sign is applied when the result is stored.
module seq_mul
   import arith_pkg::*;
#(
   parameter int WIDTH = ARITH_WIDTH
) (
   input  logic      clk,
   input  logic      rst_n,
   seq_mul_if.slave  bus
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH + 1);

   arith_state_e     state_q, state_d;
   logic [PW-1:0]    mcand_q, mcand_d;
   logic [WIDTH:0]   mplier_q, mplier_d;
   logic [PW-1:0]    acc_q, acc_d;
   logic [CW-1:0]    count_q, count_d;
   logic             neg_q, neg_d;
   logic [PW-1:0]    product_q, product_d;

   logic [WIDTH:0]   a_ext, b_ext;
   logic [WIDTH:0]   a_mag, b_mag;
   logic [PW-1:0]    acc_sum;

   // One extra bit keeps the magnitude of the most negative operand representable.
   always_comb begin
      a_ext = bus.is_signed ? {bus.a[WIDTH-1], bus.a} : {1'b0, bus.a};
      b_ext = bus.is_signed ? {bus.b[WIDTH-1], bus.b} : {1'b0, bus.b};
      a_mag = a_ext[WIDTH] ? -a_ext : a_ext;
      b_mag = b_ext[WIDTH] ? -b_ext : b_ext;
      acc_sum = acc_q + (mplier_q[0] ? mcand_q : {PW{1'b0}});
   end

   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      count_d   = count_q;
      neg_d     = neg_q;
      product_d = product_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               mcand_d  = {{(PW-WIDTH-1){1'b0}}, a_mag};
               mplier_d = b_mag;
               neg_d    = bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
               acc_d    = '0;
               count_d  = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + CW'(1);
            // The final step stores the result so it is already valid in the DONE cycle.
            if (count_q == CW'(WIDTH - 1)) begin
               product_d = neg_q ? -acc_sum : acc_sum;
               state_d   = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         count_q   <= '0;
         neg_q     <= 1'b0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         count_q   <= count_d;
         neg_q     <= neg_d;
         product_q <= product_d;
      end
   end

   assign bus.busy    = (state_q != IDLE);
   assign bus.done    = (state_q == DONE);
   assign bus.product = product_q;

endmodule
